cond_flag_unit: RTL and testbench
=================================

// Module: cond_flag_unit
// PURPOSE
//  Condition-code unit for the single-cycle ARM-subset datapath.
//  - Holds the NZCV status flags in two independently enabled registers: N,Z and C,V.
//  - Evaluates the 4-bit instruction condition field against the held flags and produces CondEx.
//  - Sits between the ALU (ALUFlags) and the control gating logic (PCSrc, RegWrite, MemWrite).
// PARAMETERS
//  FLAG_W   4   status flag vector width, ordered {N,Z,C,V}; fixed at 4, not overridable in practice
// PORTS
//  clk       in   1  single clock; all state updates on the rising edge
//  reset     in   1  synchronous, active-high reset
//  FlagW     in   2  [1]=write enable for N,Z; [0]=write enable for C,V
//  Cond      in   4  instruction condition field
//  ALUFlags  in   4  {N,Z,C,V} produced by the ALU this cycle
//  CondEx    out  1  condition passed (combinational, from held Flags)
//  Flags     out  4  held {N,Z,C,V} (registered)
// BEHAVIOUR
//  - Reset: on a posedge with reset=1, Flags <= 4'b0000. Reset overrides any enable.
//  - CondEx depends only on Cond and the registered Flags. It is purely combinational,
//    zero latency, and never uses ALUFlags directly.
//  - Condition decode (N,Z,C,V = Flags[3:0]):
//    - 0000 EQ: Z
//    - 0001 NE: ~Z
//    - 0010 CS: C
//    - 0011 CC: ~C
//    - 0100 MI: N
//    - 0101 PL: ~N
//    - 0110 VS: V
//    - 0111 VC: ~V
//    - 1000 HI: C&~Z
//    - 1001 LS: ~C|Z
//    - 1010 GE: N==V
//    - 1011 LT: N!=V
//    - 1100 GT: ~Z&(N==V)
//    - 1101 LE: Z|(N!=V)
//    - 1110 AL: 1
//    - 1111: see CONFIGURATION
//  - Flag write, at posedge with reset=0:
//    - if FlagW[1]&CondEx: Flags[3:2] <= ALUFlags[3:2]
//    - if FlagW[0]&CondEx: Flags[1:0] <= ALUFlags[1:0]
//    - otherwise the corresponding pair holds its value.
//  - Gating uses CondEx computed from the OLD flags. A failed condition never updates flags.
//  - FlagW=2'b11 with CondEx=1 updates all four flags in the same edge.
//  - FlagW=00 leaves Flags unchanged regardless of ALUFlags.
//  - Immediately after reset (Flags=0): EQ=0, NE=1, GE=1, GT=1, LE=0, HI=0, LS=1.
//  - No X propagation: every Cond value yields a defined CondEx.
// CONFIGURATION
//  Macro COND_NV_NEVER_EN controls the Cond=1111 case:
//  - Defined: Cond=1111 is NV and CondEx=0. Flags can never update under it.
//  - Not defined (default): Cond=1111 is treated as unconditional and CondEx=1.
// STRUCTURE
//  - Package cond_pkg holds:
//    - typedef enum logic[3:0] cond_e {EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL,NV}
//    - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//  - Sub-module en_reg #(WIDTH): synchronous-reset, clock-enabled register; q resets to 0.
//  - Two en_reg #(2) instances hold {N,Z} and {C,V}.
//  - The condition decoder is an always_comb case statement inside cond_flag_unit.
// TESTING
//  1. Reset: assert reset 1 cycle with FlagW=11, ALUFlags=1111 -> Flags=0000; Cond=NE -> CondEx=1, Cond=EQ -> 0.
//  2. Write all: Cond=AL, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100; EQ->1, NE->0, LS->1.
//  3. Split enables: Flags=0000, Cond=AL, FlagW=01, ALUFlags=1011 -> Flags=0011 (N,Z unchanged); then FlagW=10, ALUFlags=1000 -> Flags=1011.
//  4. Gated write: Flags=0100, Cond=NE (fails), FlagW=11, ALUFlags=1010 -> Flags stays 0100.
//  5. Exhaustive decode: all 16 Cond x 16 Flags combinations checked against a reference model.
//     Check points: Flags=1001 -> GE=1, GT=1; Flags=1000 -> LT=1, LE=1.
//  6. Cond=1111, FlagW=11, ALUFlags=1111 -> CondEx=1 and Flags<=1111 without COND_NV_NEVER_EN; CondEx=0 and Flags hold with it.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types and constants for the NZCV condition-code unit.
package cond_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Bus between the ALU/decoder side and the condition-code unit.
interface cond_flag_unit_if;
    import cond_pkg::*;

    logic [1:0]        FlagW;
    logic [3:0]        Cond;
    logic [FLAG_W-1:0] ALUFlags;
    logic              CondEx;
    logic [FLAG_W-1:0] Flags;

    modport master (
        output FlagW, Cond, ALUFlags,
        input  CondEx, Flags
    );

    modport slave (
        input  FlagW, Cond, ALUFlags,
        output CondEx, Flags
    );

endinterface

// File: rtl/cond_flag_unit_en_reg.sv
// Clock-enabled register with synchronous active-high reset to zero.
module en_reg #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag holding and condition evaluation for the ARM-subset datapath.
// Macro COND_NV_NEVER_EN makes Cond=1111 a never-pass condition; default treats it as always.
module cond_flag_unit
    import cond_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    cond_flag_unit_if.slave   bus
);

    logic       cond_ex;
    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic [FLAG_W-1:0] flags;
    logic n_f, z_f, c_f, v_f;

    assign flags = {nz_q, cv_q};
    assign n_f   = flags[FLAG_N];
    assign z_f   = flags[FLAG_Z];
    assign c_f   = flags[FLAG_C];
    assign v_f   = flags[FLAG_V];

    // Condition decode against the held flags only, never the ALU's current flags
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(bus.Cond))
            EQ: cond_ex = z_f;
            NE: cond_ex = ~z_f;
            CS: cond_ex = c_f;
            CC: cond_ex = ~c_f;
            MI: cond_ex = n_f;
            PL: cond_ex = ~n_f;
            VS: cond_ex = v_f;
            VC: cond_ex = ~v_f;
            HI: cond_ex = c_f & ~z_f;
            LS: cond_ex = ~c_f | z_f;
            GE: cond_ex = (n_f == v_f);
            LT: cond_ex = (n_f != v_f);
            GT: cond_ex = ~z_f & (n_f == v_f);
            LE: cond_ex = z_f | (n_f != v_f);
            AL: cond_ex = 1'b1;
`ifdef COND_NV_NEVER_EN
            NV: cond_ex = 1'b0;
`else
            NV: cond_ex = 1'b1;
`endif
            default: cond_ex = 1'b0;
        endcase
    end

    // A failed condition gates both flag pairs so a skipped instruction leaves them intact
    en_reg #(.WIDTH(2)) u_nz_reg (
        .clk   (clk),
        .reset (reset),
        .en    (bus.FlagW[1] & cond_ex),
        .d     (bus.ALUFlags[FLAG_N:FLAG_Z]),
        .q     (nz_q)
    );

    en_reg #(.WIDTH(2)) u_cv_reg (
        .clk   (clk),
        .reset (reset),
        .en    (bus.FlagW[0] & cond_ex),
        .d     (bus.ALUFlags[FLAG_C:FLAG_V]),
        .q     (cv_q)
    );

    assign bus.CondEx = cond_ex;
    assign bus.Flags  = flags;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: expected flags queued at drive time, popped after the edge.
module tb_cond_flag_unit;
    import cond_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cond_flag_unit_if bus ();

    cond_flag_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] model_flags = 4'b0000;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: base test from Cond[3:1], inverted by Cond[0], with 111x special-cased
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = !(n ^ v);
            3'd6: base = !z && !(n ^ v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) begin
`ifdef COND_NV_NEVER_EN
            return !c[0];
`else
            return 1'b1;
`endif
        end
        return base ^ c[0];
    endfunction

    task automatic step(input string tag, input logic rst, input logic [3:0] c,
                        input logic [1:0] fw, input logic [3:0] alu, input bit chk_ce);
        logic       ce;
        logic [3:0] nxt;
        @(negedge clk);
        reset        = rst;
        bus.Cond     = c;
        bus.FlagW    = fw;
        bus.ALUFlags = alu;
        ce  = ref_cond(c, model_flags);
        nxt = model_flags;
        if (rst) begin
            nxt = 4'b0000;
        end else begin
            if (fw[1] && ce) nxt[3:2] = alu[3:2];
            if (fw[0] && ce) nxt[1:0] = alu[1:0];
        end
        exp_q.push_back(nxt);
        #1;
        if (chk_ce) check({tag, "_condex"}, {3'b000, bus.CondEx}, {3'b000, ce});
        @(posedge clk);
        #1;
        model_flags = nxt;
        if (exp_q.size() == 0) check({tag, "_qempty"}, 4'b0001, 4'b0000);
        else                   check({tag, "_flags"}, bus.Flags, exp_q.pop_front());
    endtask

    // Hold flags and check CondEx for one condition against a hand-derived value
    task automatic probe(input string tag, input logic [3:0] c, input logic lit);
        step(tag, 1'b0, c, 2'b00, 4'b1111, 1'b1);
        check({tag, "_lit"}, {3'b000, bus.CondEx}, {3'b000, lit});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.Cond     = AL;
        bus.FlagW    = 2'b11;
        bus.ALUFlags = 4'b1111;

        // Reset overrides an all-enabled write of ones
        step("reset", 1'b1, AL, 2'b11, 4'b1111, 1'b0);
        check("reset_lit", bus.Flags, 4'b0000);
        probe("rst_ne", NE, 1'b1);
        probe("rst_eq", EQ, 1'b0);
        probe("rst_ge", GE, 1'b1);
        probe("rst_gt", GT, 1'b1);
        probe("rst_le", LE, 1'b0);
        probe("rst_hi", HI, 1'b0);
        probe("rst_ls", LS, 1'b1);

        step("wr_all", 1'b0, AL, 2'b11, 4'b0100, 1'b1);
        check("wr_all_lit", bus.Flags, 4'b0100);
        probe("wr_eq", EQ, 1'b1);
        probe("wr_ne", NE, 1'b0);
        probe("wr_ls", LS, 1'b1);

        step("split_rst", 1'b1, AL, 2'b00, 4'b0000, 1'b0);
        step("split_cv", 1'b0, AL, 2'b01, 4'b1011, 1'b1);
        check("split_cv_lit", bus.Flags, 4'b0011);
        step("split_nz", 1'b0, AL, 2'b10, 4'b1000, 1'b1);
        check("split_nz_lit", bus.Flags, 4'b1011);

        step("gate_set", 1'b0, AL, 2'b11, 4'b0100, 1'b1);
        step("gated", 1'b0, NE, 2'b11, 4'b1010, 1'b1);
        check("gated_lit", bus.Flags, 4'b0100);

        step("hold00", 1'b0, AL, 2'b00, 4'b1011, 1'b1);
        check("hold00_lit", bus.Flags, 4'b0100);

        for (int f = 0; f < 16; f++) begin
            step($sformatf("dec_set_%h", f), 1'b0, AL, 2'b11, 4'(f), 1'b1);
            for (int c = 0; c < 16; c++)
                step($sformatf("dec_f%h_c%h", f, c), 1'b0, 4'(c), 2'b00, 4'($urandom_range(0, 15)), 1'b1);
        end

        step("pt_set1001", 1'b0, AL, 2'b11, 4'b1001, 1'b1);
        probe("pt_ge", GE, 1'b1);
        probe("pt_gt", GT, 1'b1);
        step("pt_set1000", 1'b0, AL, 2'b11, 4'b1000, 1'b1);
        probe("pt_lt", LT, 1'b1);
        probe("pt_le", LE, 1'b1);

        step("nv_set", 1'b0, AL, 2'b11, 4'b0000, 1'b1);
        step("nv", 1'b0, NV, 2'b11, 4'b1111, 1'b1);
`ifdef COND_NV_NEVER_EN
        check("nv_lit", bus.Flags, 4'b0000);
`else
        check("nv_lit", bus.Flags, 4'b1111);
`endif

        for (int i = 0; i < 40; i++)
            step($sformatf("rnd_%0d", i), 1'b0, 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
